prog_fifo: RTL
==============

PROG_FIFO -- requirements
Module: prog_fifo

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, data bit width (≥1).
REQ-002 Parameter FIFO_DEPTH, default 8, entry count; power of two, ≥2.
REQ-003 Parameter READ_MODE, default MODE_REG, read style: MODE_REG (registered) or MODE_FWFT (show-ahead).
REQ-004 Derived constant CW = $clog2(FIFO_DEPTH)+1, occupancy/threshold width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 flush  input  1  synchronous clear of contents.
REQ-008 wr_en  input  1  write request.
REQ-009 data_in  input  FIFO_WIDTH  write data.
REQ-010 rd_en  input  1  read request.
REQ-011 af_level  input  CW  almost-full threshold.
REQ-012 ae_level  input  CW  almost-empty threshold.
REQ-013 data_out  output  FIFO_WIDTH  read data.
REQ-014 wr_ack  output  1  registered; previous-cycle write accepted.
REQ-015 overflow  output  1  registered; previous-cycle write rejected.
REQ-016 underflow  output  1  registered; previous-cycle read rejected.
REQ-017 full, empty, almostfull, almostempty  output  1 each  combinational status from count.
REQ-018 count  output  CW  current occupancy, 0..FIFO_DEPTH.

Function
REQ-019 rd_acc = rd_en & !empty & !flush; wr_acc = wr_en & !flush & (!full | rd_acc).
REQ-020 Write while full with same-cycle accepted read SHALL succeed (pass-through); count unchanged.
REQ-021 Read while empty with same-cycle write SHALL be rejected; write accepted; count +1.
REQ-022 count next = count + wr_acc - rd_acc; never exceeds FIFO_DEPTH, never underflows.
REQ-023 wr_ptr, rd_ptr are $clog2(FIFO_DEPTH) bits, advance by 1 on accept, wrap DEPTH-1 -> 0 naturally.
REQ-024 wr_ack = wr_acc, overflow = wr_en & !wr_acc & !flush, underflow = rd_en & !rd_acc & !flush, each registered, 1-cycle latency.
REQ-025 full = (count==FIFO_DEPTH); empty = (count==0).
REQ-026 almostfull = (count >= af_level) & !full; almostempty = (count <= ae_level) & !empty.
REQ-027 MODE_REG: data_out <= mem[rd_ptr] on rd_acc, 1-cycle latency; holds otherwise.
REQ-028 MODE_FWFT: data_out = mem[rd_ptr] combinationally; valid when !empty; rd_acc pops.
REQ-029 flush has priority over wr_en/rd_en: next cycle pointers=0, count=0, wr_ack/overflow/underflow=0; MODE_REG data_out holds.
REQ-030 Threshold inputs sampled combinationally; changes take effect same cycle.

Reset
REQ-031 rst_n low SHALL immediately clear wr_ptr, rd_ptr, count, wr_ack, overflow, underflow, and MODE_REG data_out to 0.
REQ-032 During reset full=0, empty=1, almostfull/almostempty follow REQ-026 with count=0.
REQ-033 Memory contents need not be reset; reset mid-operation discards all entries.
REQ-034 Deassertion is synchronized externally; first accepted op is on first rising edge with rst_n high.

Structure
REQ-035 Package fifo_pkg SHALL hold read_mode_e {MODE_REG, MODE_FWFT} and default FIFO_WIDTH/FIFO_DEPTH constants.
REQ-036 Storage SHALL be a sub-module fifo_mem (1 write port, 1 async read port, FIFO_DEPTH x FIFO_WIDTH).
REQ-037 Pointer/count/flag logic stays in prog_fifo; no other sub-modules.

Verification (FIFO_WIDTH=16, FIFO_DEPTH=8, af_level=6, ae_level=2)
REQ-038 Reset, then 8 writes 0x0001..0x0008 -> wr_ack 1 each; count 8; full=1; almostfull=0 at 8, 1 at counts 6-7.
REQ-039 Full, wr_en only with 0xDEAD -> overflow=1 next cycle, count stays 8, 0xDEAD never read.
REQ-040 Full, wr_en+rd_en with 0x00AA -> wr_ack=1, count 8; subsequent 8 reads return 0x0002..0x0008,0x00AA.
REQ-041 Empty, wr_en+rd_en with 0x0055 -> underflow=1, wr_ack=1, count 1; MODE_FWFT data_out=0x0055 same cycle after write.
REQ-042 Count 5, flush with wr_en+rd_en high -> count 0, empty=1, no wr_ack/underflow; pointers wrap correctly on 20 subsequent write/read pairs.
REQ-043 Count 3, rst_n low mid-cycle -> count, flags, data_out 0 immediately, without clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the programmable-threshold FIFO.
package fifo_pkg;

  typedef enum logic {
    MODE_REG  = 1'b0,
    MODE_FWFT = 1'b1
  } read_mode_e;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Contents are deliberately left unreset; occupancy tracking makes stale data unreachable.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_fifo.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and
// selectable registered or first-word-fall-through read style.
module prog_fifo
  import fifo_pkg::*;
#(
  parameter  int         FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter  int         FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter  read_mode_e READ_MODE  = MODE_REG,
  localparam int         CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [CW-1:0]         af_level,
  input  logic [CW-1:0]         ae_level,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;
  logic [FIFO_WIDTH-1:0] mem_rdata;

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= af_level) && !full;
  assign almostempty = (count_q <= ae_level) && !empty;
  assign count       = count_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  // A write into a full FIFO is allowed when a read frees the slot in the same cycle.
  assign rd_acc = rd_en && !empty && !flush;
  assign wr_acc = wr_en && !flush && (!full || rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = wr_acc;
    overflow_d  = wr_en && !wr_acc && !flush;
    underflow_d = rd_en && !rd_acc && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .WIDTH(FIFO_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr_q),
    .wdata(data_in),
    .raddr(rd_ptr_q),
    .rdata(mem_rdata)
  );

  if (READ_MODE == MODE_FWFT) begin : g_fwft
    assign data_out = mem_rdata;
  end else begin : g_reg
    logic [FIFO_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_acc) dout_d = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dout_d;
    end

    assign data_out = dout_q;
  end

endmodule
